// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  localparam int unsigned DefUartDataWidth = 8;

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } state_e;

  // Ceiling log2. Callers guarantee value >= 2, so the result is never zero.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned P_NUM_REQ         = 4,
  parameter int unsigned P_UART_DATA_WIDTH = uart_pkg::DefUartDataWidth
);

  localparam int unsigned GrantW = uart_pkg::clog2(P_NUM_REQ);

  logic [P_NUM_REQ-1:0]                   i_req_valid;
  logic [P_NUM_REQ*P_UART_DATA_WIDTH-1:0] i_req_data;
  logic [P_NUM_REQ-1:0]                   i_req_last;
  logic [P_NUM_REQ-1:0]                   o_req_ready;
  logic [P_UART_DATA_WIDTH-1:0]           o_uart_tx_data;
  logic                                   o_uart_tx_valid;
  logic                                   i_uart_tx_ready;
  logic [GrantW-1:0]                      o_grant_id;
  logic                                   o_busy;

  // Arbiter side.
  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_req_last,
    input  i_uart_tx_ready,
    output o_req_ready,
    output o_uart_tx_data,
    output o_uart_tx_valid,
    output o_grant_id,
    output o_busy
  );

  // Requesters plus transmitter, as seen from outside the arbiter.
  modport master (
    output i_req_valid,
    output i_req_data,
    output i_req_last,
    output i_uart_tx_ready,
    input  o_req_ready,
    input  o_uart_tx_data,
    input  o_uart_tx_valid,
    input  o_grant_id,
    input  o_busy
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first requester above i_last, wrapping around.
module uart_rr_pick import uart_pkg::*; #(
  parameter  int unsigned P_NUM_REQ = 4,
  localparam int unsigned GrantW    = clog2(P_NUM_REQ)
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [GrantW-1:0]    i_last,
  output logic [GrantW-1:0]    o_winner,
  output logic                 o_any_req
);

  logic [2*P_NUM_REQ-1:0] dbl_req;
  logic [2*P_NUM_REQ-1:0] masked_req;
  logic                   found;

  // Doubling the vector turns the wrap-around search into a plain upward scan
  // over positions i_last+1 .. i_last+P_NUM_REQ.
  always_comb begin
    dbl_req    = {i_req, i_req};
    masked_req = '0;
    for (int i = 0; i < 2 * P_NUM_REQ; i++) begin
      masked_req[i] = dbl_req[i] && (i > int'(i_last));
    end
  end

  always_comb begin
    o_winner = '0;
    found    = 1'b0;
    for (int i = 0; i < 2 * P_NUM_REQ; i++) begin
      if (!found && masked_req[i]) begin
        found    = 1'b1;
        o_winner = GrantW'(i % P_NUM_REQ);
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter between requesters,
// with a one-entry output register in front of the transmitter.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter  int unsigned P_NUM_REQ         = 4,
  parameter  int unsigned P_UART_DATA_WIDTH = DefUartDataWidth,
  parameter  int unsigned P_MAX_BURST       = 16,
  localparam int unsigned GrantW            = clog2(P_NUM_REQ)
) (
  input logic              i_u_clk,
  input logic              i_u_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned W = P_UART_DATA_WIDTH;

  state_e                 state_q;
  logic [GrantW-1:0]      grant_q;
  logic [7:0]             beat_cnt_q;
  logic                   tx_valid_q;
  logic [W-1:0]           tx_data_q;

  logic [GrantW-1:0]      winner;
  logic                   any_req;
  logic                   slot_free;
  logic                   sel_valid;
  logic                   sel_last;
  logic [W-1:0]           sel_data;
  logic [P_NUM_REQ-1:0]   req_ready;
  logic                   accept;
  logic                   burst_full;

  uart_rr_pick #(
    .P_NUM_REQ (P_NUM_REQ)
  ) u_rr_pick (
    .i_req     (bus.i_req_valid),
    .i_last    (grant_q),
    .o_winner  (winner),
    .o_any_req (any_req)
  );

  // The output register can take a new byte when empty or draining this cycle.
  assign slot_free = !tx_valid_q || bus.i_uart_tx_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      if (grant_q == GrantW'(k)) begin
        sel_valid    = bus.i_req_valid[k];
        sel_last     = bus.i_req_last[k];
        sel_data     = bus.i_req_data[k*W +: W];
        req_ready[k] = (state_q == StLock) && slot_free;
      end
    end
  end

  assign accept     = (state_q == StLock) && slot_free && sel_valid;
  assign burst_full = (beat_cnt_q == 8'(P_MAX_BURST - 1));

  always_ff @(posedge i_u_clk or posedge i_u_rst) begin
    if (i_u_rst) begin
      state_q    <= StIdle;
      grant_q    <= GrantW'(P_NUM_REQ - 1);
      beat_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q    <= StLock;
            grant_q    <= winner;
            beat_cnt_q <= '0;
          end
        end
        StLock: begin
          // The grant survives gaps in the owner's valid; only last or the cap release it.
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (sel_last || burst_full) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (accept) begin
        tx_data_q  <= sel_data;
        tx_valid_q <= 1'b1;
      end else if (tx_valid_q && bus.i_uart_tx_ready) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_req_ready     = req_ready;
  assign bus.o_uart_tx_data  = tx_data_q;
  assign bus.o_uart_tx_valid = tx_valid_q;
  assign bus.o_grant_id      = grant_q;
  assign bus.o_busy          = (state_q == StLock) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a queue-level round-robin model predicts the
// transmitter byte stream; a monitor checks every transmitter handshake against it.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  initial forever #5 clk = ~clk;

  uart_tx_arbiter_if #(
    .P_NUM_REQ         (NREQ),
    .P_UART_DATA_WIDTH (W)
  ) bus ();

  uart_tx_arbiter #(
    .P_NUM_REQ         (NREQ),
    .P_UART_DATA_WIDTH (W),
    .P_MAX_BURST       (BURST)
  ) dut (
    .i_u_clk (clk),
    .i_u_rst (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] q_data [NREQ][$];
  bit         q_last [NREQ][$];
  logic [7:0] exp_q  [$];

  int gap   [NREQ];
  int chunk [NREQ];
  bit rnd_ready;
  bit rnd_gap;
  int stall_left;
  int force_gap_req;
  bit force_gap_used;
  int start_cyc;
  int first_tx_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int k, input logic [7:0] d, input bit last);
    q_data[k].push_back(d);
    q_last[k].push_back(last);
  endtask

  // Requesters holding data stay valid except during an owner's mid-packet gap.
  task automatic drive_inputs();
    logic [NREQ-1:0]   v;
    logic [NREQ-1:0]   l;
    logic [NREQ*W-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (q_data[k].size() > 0) begin
        v[k]       = (gap[k] == 0);
        d[k*W +: W] = q_data[k][0];
        l[k]       = q_last[k][0];
      end
    end
    bus.i_req_valid = v;
    bus.i_req_data  = d;
    bus.i_req_last  = l;
    if (stall_left > 0) begin
      bus.i_uart_tx_ready = 1'b0;
      stall_left--;
    end else begin
      bus.i_uart_tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // Reference: grants go round-robin over requesters with data left; a grant lasts
  // until a last-flagged beat or BURST beats.
  task automatic model_push(output int owner);
    int pos [NREQ];
    int beats;
    int k;
    bit found;
    bit l;
    owner = NREQ - 1;
    k     = 0;
    for (int i = 0; i < NREQ; i++) pos[i] = 0;
    forever begin
      found = 1'b0;
      for (int s = 1; s <= NREQ && !found; s++) begin
        k = (owner + s) % NREQ;
        if (pos[k] < q_data[k].size()) found = 1'b1;
      end
      if (!found) break;
      owner = k;
      beats = 0;
      do begin
        exp_q.push_back(q_data[k][pos[k]]);
        l = q_last[k][pos[k]];
        pos[k]++;
        beats++;
      end while (!l && beats < BURST && pos[k] < q_data[k].size());
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      q_data[k].delete();
      q_last[k].delete();
      gap[k]   = 0;
      chunk[k] = 0;
    end
    exp_q.delete();
    stall_left = 0;
    drive_inputs();
    #1;
    check("rst_tx_valid", bus.o_uart_tx_valid, 0);
    check("rst_tx_data", bus.o_uart_tx_data, 0);
    check("rst_grant_id", bus.o_grant_id, NREQ - 1);
    check("rst_req_ready", bus.o_req_ready, 0);
    check("rst_busy", bus.o_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NREQ; k++) if (q_data[k].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_scenario(input string name, input int stop_req, input int stop_left,
                              output bit stopped);
    int              owner;
    int              n;
    bit              done;
    bit              had_tx;
    bit              was_last;
    logic [NREQ-1:0] acc;
    model_push(owner);
    had_tx = (exp_q.size() > 0);
    for (int k = 0; k < NREQ; k++) begin
      gap[k]   = 0;
      chunk[k] = 0;
    end
    force_gap_used = 1'b0;
    first_tx_cyc   = -1;
    drive_inputs();
    start_cyc = cyc;
    n       = 0;
    done    = 1'b0;
    stopped = 1'b0;
    while (!done && !stopped && n < 3000) begin
      @(negedge clk);
      acc = bus.i_req_valid & bus.o_req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc[k] && q_data[k].size() > 0) begin
          was_last = q_last[k].pop_front();
          void'(q_data[k].pop_front());
          chunk[k]++;
          if (was_last || chunk[k] == BURST) begin
            chunk[k] = 0;
          end else if (k == force_gap_req && !force_gap_used) begin
            gap[k]         = 5;
            force_gap_used = 1'b1;
          end else if (rnd_gap && $urandom_range(0, 3) == 0) begin
            gap[k] = int'($urandom_range(1, 4));
          end
        end else if (gap[k] > 0) begin
          gap[k]--;
        end
      end
      drive_inputs();
      n++;
      if (stop_req >= 0 && q_data[stop_req].size() <= stop_left) stopped = 1'b1;
      done = all_empty() && (exp_q.size() == 0) && !bus.o_busy;
    end
    if (!stopped) begin
      check({name, "_drained"}, done, 1);
      check({name, "_final_grant"}, bus.o_grant_id, owner);
      check({name, "_idle"}, bus.o_busy, 0);
      if (had_tx) check({name, "_first_beat_latency"}, first_tx_cyc - start_cyc, 2);
    end
  endtask

  // Transmitter-side monitor: pops the scoreboard on each handshake and checks that
  // a stalled byte neither changes nor disappears.
  initial begin : monitor
    bit         hold;
    logic [7:0] hold_data;
    hold      = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (bus.o_uart_tx_valid) begin
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        check("busy_with_valid", bus.o_busy, 1);
        if (hold) check("stalled_data_stable", bus.o_uart_tx_data, hold_data);
        if (bus.i_uart_tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %02h, expected no byte", bus.o_uart_tx_data);
          end else begin
            check("tx_byte", bus.o_uart_tx_data, exp_q.pop_front());
          end
          hold = 1'b0;
        end else begin
          check("ready_low_while_stalled", bus.o_req_ready, 0);
          hold      = 1'b1;
          hold_data = bus.o_uart_tx_data;
        end
      end else begin
        if (hold) begin
          checks++;
          errors++;
          $display("FAIL stalled_byte_dropped: got valid 0, expected 1 with data %02h",
                   hold_data);
        end
        hold = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit stopped;
    int npk;
    int len;
    rnd_ready     = 1'b0;
    rnd_gap       = 1'b0;
    force_gap_req = -1;
    stall_left    = 0;

    do_reset();
    push_beat(0, 8'h11, 1'b0);
    push_beat(0, 8'h22, 1'b0);
    push_beat(0, 8'h33, 1'b1);
    run_scenario("single_pkt", -1, 0, stopped);

    do_reset();
    for (int k = 0; k < NREQ; k++) push_beat(k, 8'hA0 + 8'(k), 1'b1);
    push_beat(0, 8'hA4, 1'b1);
    run_scenario("all_four", -1, 0, stopped);

    do_reset();
    push_beat(1, 8'h5A, 1'b1);
    for (int i = 0; i < 6; i++) push_beat(2, 8'hC0 + 8'(i), i == 5);
    push_beat(1, 8'hB0, 1'b0);
    push_beat(1, 8'hB1, 1'b1);
    run_scenario("burst_cap", -1, 0, stopped);

    do_reset();
    push_beat(1, 8'h77, 1'b0);
    push_beat(1, 8'h78, 1'b1);
    stall_left = 22;
    run_scenario("ready_stall", -1, 0, stopped);

    do_reset();
    push_beat(0, 8'h11, 1'b0);
    push_beat(0, 8'h22, 1'b0);
    push_beat(0, 8'h33, 1'b1);
    run_scenario("rst_mid", 0, 1, stopped);
    check("rst_mid_reached", stopped, 1);
    do_reset();
    push_beat(0, 8'h44, 1'b1);
    push_beat(3, 8'h55, 1'b1);
    run_scenario("after_rst", -1, 0, stopped);

    do_reset();
    force_gap_req = 0;
    push_beat(0, 8'h61, 1'b0);
    push_beat(0, 8'h62, 1'b0);
    push_beat(0, 8'h63, 1'b1);
    push_beat(3, 8'hD3, 1'b1);
    run_scenario("owner_gap", -1, 0, stopped);
    force_gap_req = -1;

    rnd_ready = 1'b1;
    rnd_gap   = 1'b1;
    for (int r = 0; r < 10; r++) begin
      do_reset();
      for (int k = 0; k < NREQ; k++) begin
        npk = int'($urandom_range(0, 2));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) push_beat(k, 8'($urandom), b == len - 1);
        end
      end
      run_scenario("random", -1, 0, stopped);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
